// File: rtl/score_display_scheduler.sv
// Scans NUM_DIGITS 2-bit digits through one shared decoder onto a muxed 7-seg display; outputs lag state by 1 cycle.
// Digit sets are accepted by valid/ready (one set pending at most) and swapped in atomically at frame boundaries.
module score_display_scheduler #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [2*NUM_DIGITS-1:0] upd_data,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [1:0]              dec_bin,
   input  logic [6:0]              dec_hex,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]    SEG_OFF  = 7'h7F;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   logic [1:0]              r_state;
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [2*NUM_DIGITS-1:0] r_active;
   logic [2*NUM_DIGITS-1:0] r_pending;
   logic                    r_pend_valid;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig_en;
   logic                    r_frame_done;

   logic                    w_xfer;
   logic                    w_cnt_last;
   logic                    w_boundary;
   logic [CW-1:0]           w_cnt_nxt;
   logic [IW-1:0]           w_idx_nxt;
   logic [1:0]              w_state_nxt;
   logic                    w_lit;
   logic [NUM_DIGITS-1:0]   w_onehot;

   assign upd_ready   = ~r_pend_valid;
   assign w_xfer      = upd_valid & ~r_pend_valid;
   assign w_cnt_last  = (r_cnt == CNT_LAST);
   assign w_boundary  = (r_state != S_IDLE) && w_cnt_last && (r_idx == IDX_LAST);
   assign w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + 1'b1;
   assign w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
   assign w_state_nxt = (w_cnt_nxt < CNT_SHOW) ? S_BLANK : S_SHOW;
   assign w_lit       = (r_state == S_SHOW) && !blank_mask[r_idx];
   assign w_onehot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

   assign dec_bin    = (r_state == S_IDLE) ? 2'b00 : r_active[{r_idx, 1'b0} +: 2];
   assign seg_out    = r_seg;
   assign dig_en     = r_dig_en;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_active     <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
         r_seg        <= SEG_OFF;
         r_dig_en     <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         // Output stage samples the current slot, so the display trails the state by one cycle.
         if (w_lit) begin
            r_dig_en <= w_onehot;
            r_seg    <= dec_hex;
         end else begin
            r_dig_en <= '0;
            r_seg    <= SEG_OFF;
         end

         if (r_state == S_IDLE) begin
            if (w_xfer) begin
               r_active <= upd_data;
               r_idx    <= '0;
               r_cnt    <= '0;
               r_state  <= (CNT_SHOW == '0) ? S_SHOW : S_BLANK;
            end
         end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            if (w_cnt_last) begin
               r_idx <= w_idx_nxt;
            end
            // A transfer on the boundary edge lands in pending and waits a whole frame.
            if (w_xfer) begin
               r_pending    <= upd_data;
               r_pend_valid <= 1'b1;
            end else if (w_boundary && r_pend_valid) begin
               r_active     <= r_pending;
               r_pend_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_display_scheduler.sv
// Directed bench for score_display_scheduler (2 digits, 8-cycle slots, 2 blank cycles) with the shared decoder modelled here.
module tb_score_display_scheduler;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S1  = 7'b1111001;
   localparam logic [6:0] S2  = 7'b0100100;
   localparam logic [6:0] S3  = 7'b0110000;
   localparam logic [6:0] OFF = 7'h7F;

   logic       clk = 1'b0;
   logic       rst;
   logic       upd_valid;
   logic       upd_ready;
   logic [3:0] upd_data;
   logic [1:0] blank_mask;
   logic [1:0] dec_bin;
   logic [6:0] dec_hex;
   logic [6:0] seg_out;
   logic [1:0] dig_en;
   logic       frame_done;

   int n_assert = 0;
   int n_fail   = 0;

   score_display_scheduler #(
      .NUM_DIGITS   (2),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_data   (upd_data),
      .blank_mask (blank_mask),
      .dec_bin    (dec_bin),
      .dec_hex    (dec_hex),
      .seg_out    (seg_out),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (dec_bin)
         2'd0:    dec_hex = S0;
         2'd1:    dec_hex = S1;
         2'd2:    dec_hex = S2;
         default: dec_hex = S3;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_dark(input string tag, input logic rdy);
      chk({tag, ".en"},  32'(dig_en),     32'd0);
      chk({tag, ".seg"}, 32'(seg_out),    32'(OFF));
      chk({tag, ".fd"},  32'(frame_done), 32'd0);
      chk({tag, ".rdy"}, 32'(upd_ready),  32'(rdy));
   endtask

   // Entered in frame cycle 0 (slot 0, cnt 0); checks cycles 1..16 and optionally posts a set at cycle xfer_cyc.
   task automatic run_frame(input string tag, input logic [1:0] v0, input logic [1:0] v1,
                            input logic [6:0] seg0, input logic [6:0] seg1,
                            input logic [1:0] en0, input logic [1:0] en1, input logic [1:0] mask,
                            input bit pend_in, input int xfer_cyc, input logic [3:0] xdata,
                            input bit hold, input bit drop_end);
      logic [1:0] e_en;
      logic [6:0] e_seg;
      logic       e_rdy;
      blank_mask = mask;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) begin
            tick();
            if (c <= 2 || (c >= 9 && c <= 10)) begin
               e_en = 2'b00; e_seg = OFF;
            end else if (c <= 8) begin
               e_en = en0; e_seg = seg0;
            end else begin
               e_en = en1; e_seg = seg1;
            end
            if (pend_in)
               e_rdy = (c == 16);
            else if (xfer_cyc >= 0 && c > xfer_cyc)
               e_rdy = (c == 16 && xfer_cyc < 15);
            else
               e_rdy = 1'b1;
            chk($sformatf("%s.c%0d.en", tag, c),  32'(dig_en),     32'(e_en));
            chk($sformatf("%s.c%0d.seg", tag, c), 32'(seg_out),    32'(e_seg));
            chk($sformatf("%s.c%0d.fd", tag, c),  32'(frame_done), 32'(c == 16));
            chk($sformatf("%s.c%0d.rdy", tag, c), 32'(upd_ready),  32'(e_rdy));
            if (c == 4)  chk($sformatf("%s.dec0", tag), 32'(dec_bin), 32'(v0));
            if (c == 12) chk($sformatf("%s.dec1", tag), 32'(dec_bin), 32'(v1));
         end
         if (c == xfer_cyc) begin
            upd_valid = 1'b1;
            upd_data  = xdata;
         end else if (xfer_cyc >= 0 && c == xfer_cyc + 1) begin
            if (hold) upd_data = ~xdata;
            else      upd_valid = 1'b0;
         end
         if (c == 16 && drop_end) upd_valid = 1'b0;
      end
   endtask

   initial begin
      rst        = 1'b1;
      upd_valid  = 1'b0;
      upd_data   = 4'b0000;
      blank_mask = 2'b00;
      tick();
      tick();
      chk_dark("rst", 1'b1);
      rst = 1'b0;

      // Idle after reset: dark, ready, no frame pulses.
      for (int i = 0; i < 40; i++) begin
         tick();
         chk_dark($sformatf("idle.%0d", i), 1'b1);
      end
      chk("idle.dec", 32'(dec_bin), 32'd0);

      // First set from IDLE goes straight to the active set.
      upd_valid = 1'b1;
      upd_data  = 4'b1001;
      tick();
      upd_valid = 1'b0;
      chk_dark("t2.c0", 1'b1);
      chk("t2.c0.dec", 32'(dec_bin), 32'd1);
      run_frame("t2a", 2'd1, 2'd2, S1, S2, 2'b01, 2'b10, 2'b00, 1'b0, -1, 4'b0000, 1'b0, 1'b0);
      run_frame("t2b", 2'd1, 2'd2, S1, S2, 2'b01, 2'b10, 2'b00, 1'b0, -1, 4'b0000, 1'b0, 1'b0);

      // Mid-frame post: old digits finish the frame, new set shows next frame.
      run_frame("t3a", 2'd1, 2'd2, S1, S2, 2'b01, 2'b10, 2'b00, 1'b0, 5, 4'b1111, 1'b0, 1'b0);
      run_frame("t3b", 2'd3, 2'd3, S3, S3, 2'b01, 2'b10, 2'b00, 1'b0, -1, 4'b0000, 1'b0, 1'b0);

      // Post on the boundary edge, then hold valid with different data while not ready.
      run_frame("t4a", 2'd3, 2'd3, S3, S3, 2'b01, 2'b10, 2'b00, 1'b0, 15, 4'b0010, 1'b1, 1'b0);
      run_frame("t4b", 2'd3, 2'd3, S3, S3, 2'b01, 2'b10, 2'b00, 1'b1, -1, 4'b0000, 1'b0, 1'b1);
      run_frame("t4c", 2'd2, 2'd0, S2, S0, 2'b01, 2'b10, 2'b00, 1'b0, -1, 4'b0000, 1'b0, 1'b0);

      // Digit 1 masked dark.
      run_frame("t5", 2'd2, 2'd0, S2, OFF, 2'b01, 2'b00, 2'b10, 1'b0, -1, 4'b0000, 1'b0, 1'b0);
      blank_mask = 2'b00;

      // Reset during digit 1 SHOW with a set pending.
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 3) begin
            upd_valid = 1'b1;
            upd_data  = 4'b1111;
         end
         if (c == 4) begin
            upd_valid = 1'b0;
            chk("t6.pend.rdy", 32'(upd_ready), 32'd0);
         end
      end
      chk("t6.c12.en",  32'(dig_en),  32'(2'b10));
      chk("t6.c12.seg", 32'(seg_out), 32'(S0));
      rst = 1'b1;
      tick();
      chk_dark("t6.rst", 1'b1);
      chk("t6.rst.dec", 32'(dec_bin), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_dark($sformatf("t6.idle.%0d", i), 1'b1);
      end

      upd_valid = 1'b1;
      upd_data  = 4'b0111;
      tick();
      upd_valid = 1'b0;
      chk_dark("t6b.c0", 1'b1);
      run_frame("t6b", 2'd3, 2'd1, S3, S1, 2'b01, 2'b10, 2'b00, 1'b0, -1, 4'b0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
